// File: rtl/avalon_packet_arbiter_pkg.sv
// Shared types, default widths and the width helper for the packet arbiter.
// Imported by the interface, the round-robin picker and the arbiter top.
package avalon_packet_arbiter_pkg;

  typedef enum logic [0:0] {
    StArb,
    StPkt
  } arb_state_t;

  localparam int unsigned DefNumSources       = 4;
  localparam int unsigned DefDataWidthInBytes = 8;
  localparam int unsigned DefEmptyW           = 3;
  localparam int unsigned DefStallTimeout     = 255;

  // Bits needed to index n items; never less than one.
  function automatic int unsigned log2up_func(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/avalon_packet_arbiter_if.sv
// Bundle of the N-to-1 Avalon-ST signals seen by the packet arbiter.
// The arbiter takes the slave view; the upstream sources and downstream sink take the master view.
interface avalon_packet_arbiter_if
  import avalon_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES         = DefNumSources,
  parameter int unsigned DATA_WIDTH_IN_BYTES = DefDataWidthInBytes,
  parameter int unsigned EMPTY_W             = DefEmptyW
);

  localparam int unsigned DataW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int unsigned IdW   = log2up_func(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]         src_enable;
  logic [NUM_SOURCES-1:0]         in_valid;
  logic [NUM_SOURCES-1:0]         in_rdy;
  logic [NUM_SOURCES-1:0]         in_sop;
  logic [NUM_SOURCES-1:0]         in_eop;
  logic [NUM_SOURCES*EMPTY_W-1:0] in_empty;
  logic [NUM_SOURCES*DataW-1:0]   in_data;

  logic               out_valid;
  logic               out_rdy;
  logic               out_sop;
  logic               out_eop;
  logic [EMPTY_W-1:0] out_empty;
  logic [DataW-1:0]   out_data;
  logic [IdW-1:0]     out_src_id;
  logic               stall_timeout_indi;

  modport slave (
    input  src_enable, in_valid, in_sop, in_eop, in_empty, in_data, out_rdy,
    output in_rdy, out_valid, out_sop, out_eop, out_empty, out_data, out_src_id,
           stall_timeout_indi
  );

  modport master (
    output src_enable, in_valid, in_sop, in_eop, in_empty, in_data, out_rdy,
    input  in_rdy, out_valid, out_sop, out_eop, out_empty, out_data, out_src_id,
           stall_timeout_indi
  );

endinterface

// File: rtl/avalon_packet_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first requester strictly after last_i, wrapping to 0.
module avalon_packet_arbiter_rr_priority_picker
  import avalon_packet_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  localparam int unsigned IdxW = log2up_func(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  // Walk offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int off = int'(N); off >= 1; off--) begin
      if (req_i[(int'(last_i) + off) % int'(N)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'((int'(last_i) + off) % int'(N));
      end
    end
  end

endmodule

// File: rtl/avalon_packet_arbiter.sv
// Packet-level round-robin arbiter: grant held sop..eop, registered output stage,
// per-source enable sampled at arbitration and a stall watchdog that drops hung grants.
module avalon_packet_arbiter
  import avalon_packet_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SOURCES         = DefNumSources,
  parameter int unsigned DATA_WIDTH_IN_BYTES = DefDataWidthInBytes,
  parameter int unsigned EMPTY_W             = DefEmptyW,
  parameter int unsigned STALL_TIMEOUT       = DefStallTimeout
) (
  input logic                    clk,
  input logic                    rst,
  avalon_packet_arbiter_if.slave bus
);

  localparam int unsigned DataW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int unsigned IdW   = log2up_func(NUM_SOURCES);
  localparam int unsigned CntW  = log2up_func(STALL_TIMEOUT + 1);
  localparam logic [CntW-1:0] StallLast = CntW'(STALL_TIMEOUT - 1);
  localparam logic [IdW-1:0]  LastInit  = IdW'(NUM_SOURCES - 1);

  arb_state_t         state_q;
  logic [IdW-1:0]     grant_q;
  logic [IdW-1:0]     last_q;
  logic [CntW-1:0]    stall_cnt_q;
  logic               stall_pulse_q;
  logic               out_valid_q;
  logic               out_sop_q;
  logic               out_eop_q;
  logic [EMPTY_W-1:0] out_empty_q;
  logic [DataW-1:0]   out_data_q;
  logic [IdW-1:0]     out_src_id_q;

  logic [NUM_SOURCES-1:0] req;
  logic                   pick_valid;
  logic [IdW-1:0]         pick_idx;
  logic                   sel_valid;
  logic                   sel_sop;
  logic                   sel_eop;
  logic [EMPTY_W-1:0]     sel_empty;
  logic [DataW-1:0]       sel_data;
  logic                   can_take;
  logic                   in_acc;

  // Only a packet head from an enabled source may win arbitration.
  assign req = bus.in_valid & bus.in_sop & bus.src_enable;

  avalon_packet_arbiter_rr_priority_picker #(
    .N (NUM_SOURCES)
  ) u_picker (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    sel_valid = bus.in_valid[grant_q];
    sel_sop   = bus.in_sop[grant_q];
    sel_eop   = bus.in_eop[grant_q];
    sel_empty = bus.in_empty[grant_q*EMPTY_W +: EMPTY_W];
    sel_data  = bus.in_data[grant_q*DataW +: DataW];
    can_take  = (state_q == StPkt) && (!out_valid_q || bus.out_rdy);
    in_acc    = sel_valid && can_take;
    bus.in_rdy = '0;
    if (can_take) begin
      bus.in_rdy[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StArb;
      grant_q       <= '0;
      last_q        <= LastInit;
      stall_cnt_q   <= '0;
      stall_pulse_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_empty_q   <= '0;
      out_data_q    <= '0;
      out_src_id_q  <= '0;
    end else begin
      stall_pulse_q <= 1'b0;

      if (in_acc) begin
        out_valid_q  <= 1'b1;
        out_sop_q    <= sel_sop;
        out_eop_q    <= sel_eop;
        out_empty_q  <= sel_eop ? sel_empty : '0;
        out_data_q   <= sel_data;
        out_src_id_q <= grant_q;
      end else if (bus.out_rdy) begin
        out_valid_q <= 1'b0;
      end

      unique case (state_q)
        StArb: begin
          if (pick_valid) begin
            grant_q     <= pick_idx;
            last_q      <= pick_idx;
            stall_cnt_q <= '0;
            state_q     <= StPkt;
          end
        end
        StPkt: begin
          if (in_acc) begin
            stall_cnt_q <= '0;
            if (sel_eop) begin
              state_q <= StArb;
            end
          end else if (!sel_valid && (STALL_TIMEOUT != 0)) begin
            // Source went quiet mid-packet; no eop is synthesised, downstream flags the cut.
            if (stall_cnt_q == StallLast) begin
              stall_cnt_q   <= '0;
              stall_pulse_q <= 1'b1;
              state_q       <= StArb;
            end else begin
              stall_cnt_q <= stall_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StArb;
      endcase
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.out_sop            = out_sop_q;
  assign bus.out_eop            = out_eop_q;
  assign bus.out_empty          = out_empty_q;
  assign bus.out_data           = out_data_q;
  assign bus.out_src_id         = out_src_id_q;
  assign bus.stall_timeout_indi = stall_pulse_q;

endmodule

// File: tb/tb_avalon_packet_arbiter.sv
// Randomised bench for avalon_packet_arbiter: packet-level round-robin reference model,
// latency/stability monitors, watchdog and mid-packet reset scenarios.
module tb_avalon_packet_arbiter;
  import avalon_packet_arbiter_pkg::*;

  localparam int unsigned NS = 4;
  localparam int unsigned DB = 8;
  localparam int unsigned EW = 3;
  localparam int unsigned ST = 8;
  localparam int unsigned DW = DB * 8;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  typedef struct packed {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } obeat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  avalon_packet_arbiter_if #(
    .NUM_SOURCES         (NS),
    .DATA_WIDTH_IN_BYTES (DB),
    .EMPTY_W             (EW)
  ) bus ();

  avalon_packet_arbiter #(
    .NUM_SOURCES         (NS),
    .DATA_WIDTH_IN_BYTES (DB),
    .EMPTY_W             (EW),
    .STALL_TIMEOUT       (ST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          model_last;

  beat_t       src_q   [NS][$];
  beat_t       model_q [NS][$];
  obeat_t      exp_q   [$];
  int unsigned acc_cyc_q [$];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [127:0] outs_vec();
    return {bus.in_rdy, bus.stall_timeout_indi, bus.out_valid, bus.out_sop, bus.out_eop,
            bus.out_empty, bus.out_data, bus.out_src_id};
  endfunction

  function automatic logic [127:0] out_beat();
    return {bus.out_src_id, bus.out_data, bus.out_sop, bus.out_eop, bus.out_empty};
  endfunction

  task automatic clear_inputs();
    bus.in_valid = '0;
    bus.in_sop   = '0;
    bus.in_eop   = '0;
    bus.in_empty = '0;
    bus.in_data  = '0;
    bus.out_rdy  = 1'b1;
  endtask

  task automatic set_src(input int i, input logic v, input logic s, input logic e,
                         input logic [DW-1:0] d, input logic [EW-1:0] em);
    bus.in_valid[i]          = v;
    bus.in_sop[i]            = s;
    bus.in_eop[i]            = e;
    bus.in_data[i*DW +: DW]  = d;
    bus.in_empty[i*EW +: EW] = em;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    #1;
    check_eq("reset_outputs", outs_vec(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_last = NS - 1;
  endtask

  // Expected output stream: whole packets in round-robin order over enabled sources with work.
  task automatic build_model(input logic [NS-1:0] en);
    beat_t b;
    int    g;
    while (1) begin
      g = -1;
      for (int off = 1; off <= NS; off++) begin
        int c;
        c = (model_last + off) % NS;
        if (g < 0 && en[c] && model_q[c].size() != 0) g = c;
      end
      if (g < 0) break;
      do begin
        b = model_q[g].pop_front();
        exp_q.push_back({IW'(g), b.data, b.sop, b.eop, b.eop ? b.empty : '0});
      end while (!b.eop);
      model_last = g;
    end
  endtask

  // rdy_mode: 0 = always ready, 1 = toggling, 2 = random.
  task automatic run_scenario(input string name, input logic [NS-1:0] active,
                              input logic [NS-1:0] en, input int npkt, input int minlen,
                              input int maxlen, input bit gaps, input int rdy_mode,
                              input bit strict);
    beat_t             b;
    obeat_t            e;
    logic [NS-1:0]     acc;
    int                gap_run [NS];
    bit                prev_ov, prev_oacc, have_prev;
    logic [127:0]      prev_beat;
    int unsigned       prev_out_cyc, ac;
    bit                prev_eop;

    exp_q.delete();
    acc_cyc_q.delete();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      gap_run[i] = 0;
      if (active[i]) begin
        for (int p = 0; p < npkt; p++) begin
          int len;
          len = $urandom_range(minlen, maxlen);
          for (int k = 0; k < len; k++) begin
            b.data  = {$urandom, $urandom};
            b.sop   = (k == 0);
            b.eop   = (k == len - 1);
            b.empty = EW'($urandom);
            src_q[i].push_back(b);
          end
        end
      end
      model_q[i] = src_q[i];
    end
    build_model(en);

    prev_ov = 0; prev_oacc = 0; have_prev = 0; prev_beat = '0; prev_out_cyc = 0; prev_eop = 0;
    @(posedge clk);
    #1;
    bus.src_enable = en;
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (src_q[i].size() != 0) begin
          logic v;
          b = src_q[i][0];
          if (!b.sop && gaps && gap_run[i] < 3 && $urandom_range(0, 3) == 0) begin
            v = 1'b0;
            gap_run[i]++;
          end else begin
            v = 1'b1;
            gap_run[i] = 0;
          end
          set_src(i, v, b.sop, b.eop, b.data, b.empty);
        end else begin
          set_src(i, 1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom}, EW'($urandom));
        end
      end
      case (rdy_mode)
        1:       bus.out_rdy = c[0];
        2:       bus.out_rdy = ($urandom_range(0, 3) != 0);
        default: bus.out_rdy = 1'b1;
      endcase

      @(negedge clk);
      check_eq({name, "/in_rdy_onehot0"}, 128'($onehot0(bus.in_rdy)), 1);
      acc = bus.in_valid & bus.in_rdy;
      if (acc != '0) acc_cyc_q.push_back(cyc);
      if (bus.out_valid) begin
        if (!prev_ov || prev_oacc) begin
          ac = (acc_cyc_q.size() != 0) ? acc_cyc_q.pop_front() : 0;
          check_eq({name, "/latency"}, 128'(cyc), 128'(ac + 1));
        end else begin
          check_eq({name, "/held_stable"}, out_beat(), prev_beat);
        end
      end
      if (bus.out_valid && bus.out_rdy) begin
        if (exp_q.size() == 0) begin
          check_eq({name, "/extra_beat"}, out_beat(), '0);
        end else begin
          e = exp_q.pop_front();
          check_eq({name, "/beat"}, out_beat(), 128'(e));
          if (strict && have_prev) begin
            check_eq({name, "/beat_spacing"}, 128'(cyc - prev_out_cyc),
                     prev_eop ? 128'(2) : 128'(1));
          end
          have_prev    = 1;
          prev_out_cyc = cyc;
          prev_eop     = e.eop;
        end
      end
      prev_ov   = bus.out_valid;
      prev_oacc = bus.out_valid && bus.out_rdy;
      prev_beat = out_beat();

      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      end
    end

    check_eq({name, "/all_beats_out"}, 128'(exp_q.size()), 0);
    for (int i = 0; i < NS; i++) src_q[i].delete();
    clear_inputs();
    repeat (3) @(negedge clk);
    check_eq({name, "/drain_idle"}, 128'(bus.out_valid), 0);
  endtask

  task automatic watchdog_test();
    int c0, cp;
    c0 = -1;
    cp = -1;
    do_reset();
    @(posedge clk);
    #1;
    bus.src_enable = '1;
    set_src(2, 1'b1, 1'b1, 1'b0, 64'hA5A5_0002_0000_0001, '0);
    set_src(3, 1'b1, 1'b1, 1'b1, 64'hA5A5_0003_0000_0001, 3'd5);
    for (int c = 0; c < 10 && c0 < 0; c++) begin
      @(negedge clk);
      if (bus.in_rdy != '0) begin
        check_eq("wd/first_grant", 128'(bus.in_rdy), 128'(4'b0100));
        c0 = int'(cyc);
      end
    end
    if (c0 < 0) check_eq("wd/grant_timeout", 0, 1);
    @(posedge clk);
    #1;
    set_src(2, 1'b0, 1'b0, 1'b0, '0, '0);
    for (int c = 0; c < 20 && cp < 0; c++) begin
      @(negedge clk);
      if (bus.stall_timeout_indi) begin
        cp = int'(cyc);
        check_eq("wd/no_rdy_on_release", 128'(bus.in_rdy), 0);
      end
    end
    check_eq("wd/release_delay", 128'(cp - c0), 9);
    @(negedge clk);
    check_eq("wd/pulse_width", 128'(bus.stall_timeout_indi), 0);
    check_eq("wd/next_grant", 128'(bus.in_rdy), 128'(4'b1000));
    @(posedge clk);
    #1;
    clear_inputs();
    @(negedge clk);
    check_eq("wd/src3_beat", out_beat(), {2'd3, 64'hA5A5_0003_0000_0001, 1'b1, 1'b1, 3'd5});
    model_last = 3;
  endtask

  task automatic reset_test();
    bit granted;
    granted = 0;
    @(posedge clk);
    #1;
    bus.src_enable = '1;
    set_src(1, 1'b1, 1'b1, 1'b0, 64'h1111, '0);
    for (int c = 0; c < 10 && !granted; c++) begin
      @(negedge clk);
      if (bus.in_rdy != '0) begin
        check_eq("rst/pre_grant", 128'(bus.in_rdy), 128'(4'b0010));
        granted = 1;
      end
    end
    if (!granted) check_eq("rst/pre_grant_timeout", 0, 1);
    @(posedge clk);
    #1;
    set_src(1, 1'b1, 1'b0, 1'b0, 64'h2222, '0);
    @(negedge clk);
    check_eq("rst/mid_pkt_valid", 128'(bus.out_valid), 1);
    #2;
    rst = 1'b0;
    for (int i = 0; i < NS; i++) set_src(i, 1'b1, 1'b1, 1'b1, 64'(i + 16), '0);
    #1;
    check_eq("rst/async_clear", outs_vec(), '0);
    @(negedge clk);
    rst = 1'b1;
    granted = 0;
    for (int c = 0; c < 10 && !granted; c++) begin
      @(negedge clk);
      if (bus.in_rdy != '0) begin
        check_eq("rst/first_grant", 128'(bus.in_rdy), 128'(4'b0001));
        granted = 1;
      end
    end
    if (!granted) check_eq("rst/grant_timeout", 0, 1);
    @(posedge clk);
    #1;
    clear_inputs();
    repeat (3) @(negedge clk);
    model_last = 0;
  endtask

  initial begin
    logic [NS-1:0] en;
    bus.src_enable = '1;
    clear_inputs();
    do_reset();
    run_scenario("single_src0", 4'b0001, 4'b1111, 1, 3, 3, 0, 0, 1);
    run_scenario("all_rr",      4'b1111, 4'b1111, 2, 2, 2, 0, 0, 1);
    run_scenario("enable_mask", 4'b1111, 4'b1010, 3, 1, 3, 0, 0, 1);
    run_scenario("backpress",   4'b0001, 4'b1111, 1, 4, 4, 0, 1, 0);
    for (int s = 0; s < 4; s++) begin
      en = NS'($urandom_range(1, 15));
      run_scenario("random", 4'b1111, en, 4, 1, 5, 1, 2, 0);
    end
    watchdog_test();
    reset_test();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
